// File: rtl/charmap_scroll_pkg.sv
// Shared constants for the scrolling character-map renderer: RGB332 layout,
// glyph geometry and the fixed pipeline depth.
package charmap_scroll_pkg;

    localparam int PIPE_LATENCY = 4;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 8;
    localparam int GLYPH_W_LOG = 3;
    localparam int GLYPH_H_LOG = 3;

    localparam int R_LSB = 0;
    localparam int R_W   = 3;
    localparam int G_LSB = 3;
    localparam int G_W   = 3;
    localparam int B_LSB = 6;
    localparam int B_W   = 2;

    typedef logic [7:0] rgb332_t;

endpackage

// File: rtl/charmap_scroll_if.sv
// Beam, config, RAM and pixel signals of the character-map renderer.
// The master side is the timing generator / RAMs / mixer, the slave is the renderer.
interface charmap_scroll_if #(
    parameter int COLS_LOG       = 6,
    parameter int ROWS_LOG       = 6,
    parameter int FONT_BANKS_LOG = 1
);
    logic                         ce_pix;
    logic [8:0]                   hcnt;
    logic [8:0]                   vcnt;
    logic                         hblank;
    logic                         vblank;
    logic [COLS_LOG+2:0]          scroll_x;
    logic [ROWS_LOG+2:0]          scroll_y;
    logic [FONT_BANKS_LOG-1:0]    font_bank;
    logic                         cfg_we;
    logic [7:0]                   chmap_data_out;
    logic [7:0]                   fgcolram_data_out;
    logic [7:0]                   bgcolram_data_out;
    logic [7:0]                   chrom_data_out;
    logic [COLS_LOG+ROWS_LOG-1:0] chram_addr;
    logic [FONT_BANKS_LOG+10:0]   chrom_addr;
    logic [2:0]                   r;
    logic [2:0]                   g;
    logic [1:0]                   b;
    logic                         a;
    logic                         de;

    modport master (
        output ce_pix, hcnt, vcnt, hblank, vblank,
        output scroll_x, scroll_y, font_bank, cfg_we,
        output chmap_data_out, fgcolram_data_out, bgcolram_data_out, chrom_data_out,
        input  chram_addr, chrom_addr, r, g, b, a, de
    );

    modport slave (
        input  ce_pix, hcnt, vcnt, hblank, vblank,
        input  scroll_x, scroll_y, font_bank, cfg_we,
        input  chmap_data_out, fgcolram_data_out, bgcolram_data_out, chrom_data_out,
        output chram_addr, chrom_addr, r, g, b, a, de
    );

endinterface

// File: rtl/charmap_pixel_out.sv
// Final pipeline stage: picks the glyph bit for the pixel column, chooses fg/bg
// colour, gates everything to zero when blanked, and registers the result.
module charmap_pixel_out
    import charmap_scroll_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_pix_i,
    input  logic                   show_i,
    input  logic [GLYPH_W-1:0]     font_row_i,
    input  rgb332_t                fg_i,
    input  rgb332_t                bg_i,
    input  logic [GLYPH_W_LOG-1:0] col_i,
    output logic [R_W-1:0]         r_o,
    output logic [G_W-1:0]         g_o,
    output logic [B_W-1:0]         b_o,
    output logic                   a_o,
    output logic                   de_o
);

    logic [GLYPH_W_LOG-1:0] bit_sel;
    logic                   pix_bit;
    rgb332_t                colour;
    logic [R_W-1:0]         r_d, r_q;
    logic [G_W-1:0]         g_d, g_q;
    logic [B_W-1:0]         b_d, b_q;
    logic                   a_d, a_q;
    logic                   de_q;

    // Bit 7 is the leftmost pixel, so 7 - col is simply the inverted column.
    assign bit_sel = ~col_i;
    assign pix_bit = font_row_i[bit_sel];
    assign colour  = pix_bit ? fg_i : bg_i;

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        a_d = 1'b0;
        if (show_i) begin
            r_d = colour[R_LSB +: R_W];
            g_d = colour[G_LSB +: G_W];
            b_d = colour[B_LSB +: B_W];
            a_d = pix_bit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            a_q  <= 1'b0;
            de_q <= 1'b0;
        end else if (ce_pix_i) begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            a_q  <= a_d;
            de_q <= show_i;
        end
    end

    assign r_o  = r_q;
    assign g_o  = g_q;
    assign b_o  = b_q;
    assign a_o  = a_q;
    assign de_o = de_q;

endmodule

// File: rtl/charmap_scroll.sv
// Scrolling character-map renderer: beam position -> RGB332 pixel through a
// 4-stage ce_pix pipeline, with scroll and font bank latched at vblank rise.
module charmap_scroll
    import charmap_scroll_pkg::*;
#(
    parameter int COLS_LOG       = 6,
    parameter int ROWS_LOG       = 6,
    parameter int FONT_BANKS_LOG = 1
) (
    input  logic              clk,
    input  logic              reset,
    charmap_scroll_if.slave   bus
);

    localparam int XW = COLS_LOG + GLYPH_W_LOG;
    localparam int YW = ROWS_LOG + GLYPH_H_LOG;

    logic [XW-1:0]             scroll_x_pend_q, scroll_x_act_q;
    logic [YW-1:0]             scroll_y_pend_q, scroll_y_act_q;
    logic [FONT_BANKS_LOG-1:0] bank_pend_q, bank_act_q;
    logic                      vblank_prev_q;
    logic                      vblank_rise;

    logic [XW-1:0]             ex_d, ex0_q;
    logic [YW-1:0]             ey_d, ey0_q;
    logic                      blank0_q, vld0_q;

    logic [7:0]                glyph1_q;
    rgb332_t                   fg1_q, bg1_q;
    logic [GLYPH_W_LOG-1:0]    col1_q;
    logic [GLYPH_H_LOG-1:0]    row1_q;
    logic                      blank1_q, vld1_q;

    logic [GLYPH_W-1:0]        font2_q;
    rgb332_t                   fg2_q, bg2_q;
    logic [GLYPH_W_LOG-1:0]    col2_q;
    logic                      blank2_q, vld2_q;

    assign vblank_rise = bus.ce_pix & bus.vblank & ~vblank_prev_q;

    // Pending config follows cfg_we at any time; active copies the old pending
    // value on the vblank rise, so a coincident write lands one frame later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_x_pend_q <= '0;
            scroll_y_pend_q <= '0;
            bank_pend_q     <= '0;
            scroll_x_act_q  <= '0;
            scroll_y_act_q  <= '0;
            bank_act_q      <= '0;
            vblank_prev_q   <= 1'b0;
        end else begin
            if (bus.cfg_we) begin
                scroll_x_pend_q <= bus.scroll_x;
                scroll_y_pend_q <= bus.scroll_y;
                bank_pend_q     <= bus.font_bank;
            end
            if (vblank_rise) begin
                scroll_x_act_q <= scroll_x_pend_q;
                scroll_y_act_q <= scroll_y_pend_q;
                bank_act_q     <= bank_pend_q;
            end
            if (bus.ce_pix) begin
                vblank_prev_q <= bus.vblank;
            end
        end
    end

    assign ex_d = XW'(bus.hcnt) + scroll_x_act_q;
    assign ey_d = YW'(bus.vcnt) + scroll_y_act_q;

    // The vld bits keep de low until the first real pixel reaches the output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex0_q    <= '0;
            ey0_q    <= '0;
            blank0_q <= 1'b0;
            vld0_q   <= 1'b0;
            glyph1_q <= '0;
            fg1_q    <= '0;
            bg1_q    <= '0;
            col1_q   <= '0;
            row1_q   <= '0;
            blank1_q <= 1'b0;
            vld1_q   <= 1'b0;
            font2_q  <= '0;
            fg2_q    <= '0;
            bg2_q    <= '0;
            col2_q   <= '0;
            blank2_q <= 1'b0;
            vld2_q   <= 1'b0;
        end else if (bus.ce_pix) begin
            ex0_q    <= ex_d;
            ey0_q    <= ey_d;
            blank0_q <= bus.hblank | bus.vblank;
            vld0_q   <= 1'b1;
            glyph1_q <= bus.chmap_data_out;
            fg1_q    <= bus.fgcolram_data_out;
            bg1_q    <= bus.bgcolram_data_out;
            col1_q   <= ex0_q[GLYPH_W_LOG-1:0];
            row1_q   <= ey0_q[GLYPH_H_LOG-1:0];
            blank1_q <= blank0_q;
            vld1_q   <= vld0_q;
            font2_q  <= bus.chrom_data_out;
            fg2_q    <= fg1_q;
            bg2_q    <= bg1_q;
            col2_q   <= col1_q;
            blank2_q <= blank1_q;
            vld2_q   <= vld1_q;
        end
    end

    assign bus.chram_addr = {ey0_q[YW-1:GLYPH_H_LOG], ex0_q[XW-1:GLYPH_W_LOG]};
    assign bus.chrom_addr = {bank_act_q, glyph1_q, row1_q};

    charmap_pixel_out u_pixel_out (
        .clk        (clk),
        .reset      (reset),
        .ce_pix_i   (bus.ce_pix),
        .show_i     (vld2_q & ~blank2_q),
        .font_row_i (font2_q),
        .fg_i       (fg2_q),
        .bg_i       (bg2_q),
        .col_i      (col2_q),
        .r_o        (bus.r),
        .g_o        (bus.g),
        .b_o        (bus.b),
        .a_o        (bus.a),
        .de_o       (bus.de)
    );

endmodule

// File: tb/tb_charmap_scroll.sv
// Directed bench for charmap_scroll: driver pushes hand-computed pixels into a
// scoreboard, a monitor pops one per ce_pix once the pipeline is full.
module tb_charmap_scroll;
    import charmap_scroll_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    charmap_scroll_if #(.COLS_LOG(6), .ROWS_LOG(6), .FONT_BANKS_LOG(1)) bus ();

    charmap_scroll #(.COLS_LOG(6), .ROWS_LOG(6), .FONT_BANKS_LOG(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] chram_m [0:4095];
    logic [7:0] fg_m    [0:4095];
    logic [7:0] bg_m    [0:4095];
    logic [7:0] font_m  [0:4095];

    // RAMs update on the falling edge: data is ready one clk after the address moves.
    always @(negedge clk) begin
        bus.chmap_data_out    <= chram_m[bus.chram_addr];
        bus.fgcolram_data_out <= fg_m[bus.chram_addr];
        bus.bgcolram_data_out <= bg_m[bus.chram_addr];
        bus.chrom_data_out    <= font_m[bus.chrom_addr];
    end

    typedef struct packed {
        logic       chk;
        logic [9:0] px;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed_chk = 0;
    int   popped_chk = 0;

    function automatic logic [9:0] px(input logic de, input logic a, input logic [7:0] c);
        return {de, a, c};
    endfunction

    function automatic logic [9:0] act_px();
        return {bus.de, bus.a, bus.b, bus.g, bus.r};
    endfunction

    function automatic logic [11:0] faddr(input logic bank, input logic [7:0] glyph, input logic [2:0] row);
        return {bank, glyph, row};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the 4th ce pulse after a sample presents that sample's pixel.
    initial begin
        int         ce_seen;
        logic       ce_now, rst_now, last_valid;
        logic [9:0] last_px;
        exp_t       e;
        ce_seen    = 0;
        last_valid = 1'b0;
        last_px    = '0;
        forever begin
            @(posedge clk);
            ce_now  = bus.ce_pix;
            rst_now = reset;
            #1;
            if (!rst_now) begin
                ce_seen    = 0;
                last_valid = 1'b0;
            end else if (ce_now) begin
                ce_seen++;
                if (ce_seen < PIPE_LATENCY) begin
                    check("fill_zero", act_px(), 0);
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: output with no expected entry at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    last_valid = e.chk;
                    if (e.chk) begin
                        popped_chk++;
                        check("pixel", act_px(), e.px);
                        last_px = e.px;
                    end
                end
            end else if (last_valid) begin
                check("hold", act_px(), last_px);
            end
        end
    end

    task automatic step(input logic ce, input logic we, input int h, input int v,
                        input logic hb, input logic vb, input logic chk, input logic [9:0] p);
        exp_t e;
        @(negedge clk);
        bus.ce_pix = ce;
        bus.cfg_we = we;
        bus.hcnt   = 9'(h);
        bus.vcnt   = 9'(v);
        bus.hblank = hb;
        bus.vblank = vb;
        if (ce) begin
            e.chk = chk;
            e.px  = p;
            sb.push_back(e);
            if (chk) pushed_chk++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.ce_pix = 1'b0;
            bus.cfg_we = 1'b0;
            bus.hcnt   = 9'($urandom_range(0, 511));
            bus.vcnt   = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic cfg(input int sx, input int sy, input logic bank);
        bus.scroll_x  = 9'(sx);
        bus.scroll_y  = 9'(sy);
        bus.font_bank = bank;
        step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_chram(input string name, input int exp);
        @(posedge clk);
        #1;
        check(name, 32'(bus.chram_addr), exp);
    endtask

    task automatic chk_chrom(input string name, input int exp);
        @(posedge clk);
        #1;
        check(name, 32'(bus.chrom_addr), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin
            chram_m[i] = 8'h00;
            fg_m[i]    = 8'h00;
            bg_m[i]    = 8'h00;
            font_m[i]  = 8'h00;
        end
        chram_m[0]  = 8'h41; fg_m[0]  = 8'hFF; bg_m[0]  = 8'h00;
        chram_m[1]  = 8'h42; fg_m[1]  = 8'hE0; bg_m[1]  = 8'h1C;
        chram_m[64] = 8'h43; fg_m[64] = 8'h07; bg_m[64] = 8'h38;
        font_m[faddr(1'b0, 8'h41, 3'd0)] = 8'h18;
        font_m[faddr(1'b0, 8'h41, 3'd1)] = 8'h24;
        font_m[faddr(1'b0, 8'h42, 3'd0)] = 8'hF0;
        font_m[faddr(1'b0, 8'h43, 3'd0)] = 8'h0F;
        font_m[faddr(1'b1, 8'h41, 3'd2)] = 8'h81;

        bus.ce_pix = 1'b0; bus.cfg_we = 1'b0;
        bus.hcnt = '0; bus.vcnt = '0; bus.hblank = 1'b0; bus.vblank = 1'b0;
        bus.scroll_x = '0; bus.scroll_y = '0; bus.font_bank = '0;
        reset = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("rst_pixel", act_px(), 0);
        check("rst_chram", 32'(bus.chram_addr), 0);
        check("rst_chrom", 32'(bus.chrom_addr), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Defaults, ce every clk.
        step(1, 0,  3, 0, 0, 0, 1, px(1, 1, 8'hFF));
        step(1, 0,  0, 0, 0, 0, 1, px(1, 0, 8'h00));
        step(1, 0,  8, 0, 0, 0, 1, px(1, 1, 8'hE0));
        step(1, 0, 12, 0, 0, 0, 1, px(1, 0, 8'h1C));
        step(1, 0,  0, 8, 0, 0, 1, px(1, 0, 8'h38));
        step(1, 0,  7, 8, 0, 0, 1, px(1, 1, 8'h07));
        step(1, 0,  2, 1, 0, 0, 1, px(1, 1, 8'hFF));
        step(1, 0,  3, 0, 1, 0, 1, px(0, 0, 8'h00));
        step(1, 0,  7, 8, 1, 0, 1, px(0, 0, 8'h00));

        // ce every 3rd clk; monitor also checks the outputs hold in between.
        step(1, 0,  3, 0, 0, 0, 1, px(1, 1, 8'hFF)); idle(2);
        step(1, 0, 12, 0, 0, 0, 1, px(1, 0, 8'h1C)); idle(2);
        step(1, 0,  7, 8, 0, 0, 1, px(1, 1, 8'h07)); idle(2);
        step(1, 0,  0, 0, 1, 0, 1, px(0, 0, 8'h00)); idle(2);
        step(1, 0,  8, 0, 0, 0, 1, px(1, 1, 8'hE0)); idle(2);

        // X scroll with wrap.
        cfg(5, 0, 1'b0);
        step(1, 0,   3, 0, 0, 0, 1, px(1, 1, 8'hFF));
        step(1, 0,   0, 0, 0, 1, 1, px(0, 0, 8'h00));
        step(1, 0, 510, 0, 0, 0, 1, px(1, 1, 8'hFF));
        chk_chram("xwrap_chram", 0);
        step(1, 0,   3, 0, 0, 0, 1, px(1, 1, 8'hE0));
        step(1, 0, 509, 0, 0, 0, 1, px(1, 0, 8'h00));

        // Y scroll latched only at vblank rise.
        cfg(0, 8, 1'b0);
        step(1, 0, 0, 16, 0, 0, 0, '0);
        chk_chram("ty_pending", 128);
        step(1, 0, 0,  0, 0, 1, 0, '0);
        step(1, 0, 0, 16, 0, 0, 0, '0);
        chk_chram("ty_active", 192);
        step(1, 0, 0,  0, 0, 0, 1, px(1, 0, 8'h38));
        bus.scroll_y = 9'd16;
        step(1, 1, 0,  0, 0, 1, 0, '0);
        step(1, 0, 0, 16, 0, 0, 0, '0);
        chk_chram("ty_coincident", 192);
        step(1, 0, 0,  0, 0, 1, 0, '0);
        step(1, 0, 0, 16, 0, 0, 0, '0);
        chk_chram("ty_next_frame", 256);

        // Font bank 1.
        cfg(0, 0, 1'b1);
        step(1, 0, 0, 0, 0, 1, 0, '0);
        step(1, 0, 0, 2, 0, 0, 1, px(1, 1, 8'hFF));
        step(1, 0, 1, 2, 0, 0, 1, px(1, 0, 8'h00));
        chk_chrom("bank_chrom", 32'(faddr(1'b1, 8'h41, 3'd2)));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 2, 0, 0, 1, px(1, 1, 8'hFF));

        // Mid-line async reset.
        @(negedge clk);
        reset = 1'b0;
        bus.ce_pix = 1'b0;
        #1;
        check("midrst_pixel", act_px(), 0);
        check("midrst_chram", 32'(bus.chram_addr), 0);
        check("midrst_chrom", 32'(bus.chrom_addr), 0);
        foreach (sb[i]) if (sb[i].chk) pushed_chk--;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Config must be back to defaults (scroll 0, bank 0).
        step(1, 0, 3, 0, 0, 0, 1, px(1, 1, 8'hFF)); idle(2);
        step(1, 0, 8, 0, 0, 0, 1, px(1, 1, 8'hE0)); idle(2);
        step(1, 0, 0, 8, 0, 0, 1, px(1, 0, 8'h38)); idle(2);
        step(1, 0, 2, 1, 0, 0, 1, px(1, 1, 8'hFF));

        for (int i = 0; i < PIPE_LATENCY; i++) step(1, 0, 0, 0, 1, 0, 0, '0);
        idle(2);
        check("drain", 32'(popped_chk), 32'(pushed_chk));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
